fetch_sequencer: RTL and testbench

//  Owns the fetch PC and instruction-valid state for the fetch->EX->WB core.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch->EX->WB core: fetch-sequencer state and reset PC.
package cpu_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_RESET = 0;

endpackage : cpu_pkg

// File: rtl/fetch_sequencer.sv
// Fetch PC / EX-valid sequencer: drives instruction memory, squashes on redirect,
// handles stall and halt/resume, and counts retired instructions.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  input  logic              resume_i,
  output logic [ADDR_W-1:0] pc_fetch_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] pc_ex_o,
  output logic              ex_valid_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  instret_o
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  fetch_state_t      state_q,    state_nxt;
  logic [ADDR_W-1:0] pc_fetch_q, pc_fetch_nxt;
  logic [ADDR_W-1:0] pc_ex_q,    pc_ex_nxt;
  logic              ex_valid_q, ex_valid_nxt;
  logic              halted_q,   halted_nxt;
  logic [CNT_W-1:0]  instret_q,  instret_nxt;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt    = state_q;
    pc_fetch_nxt = pc_fetch_q;
    pc_ex_nxt    = pc_ex_q;
    ex_valid_nxt = ex_valid_q;
    halted_nxt   = halted_q;
    instret_nxt  = instret_q;
    mem_en_o     = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (stall_i) begin
            // Frozen: EX re-presents redirect/halt once the stall clears.
            mem_en_o = 1'b0;
          end else if (ex_valid_q && halt_i) begin
            mem_en_o     = 1'b0;
            ex_valid_nxt = 1'b0;
            halted_nxt   = 1'b1;
            state_nxt    = HALTED;
            instret_nxt  = instret_q + CNT_W'(1);
            if (redirect_i) pc_fetch_nxt = redirect_pc_i;
          end else if (ex_valid_q && redirect_i) begin
            // The fall-through fetch now in the memory is squashed: one bubble.
            mem_en_o     = 1'b1;
            pc_fetch_nxt = redirect_pc_i;
            pc_ex_nxt    = pc_fetch_q;
            ex_valid_nxt = 1'b0;
            instret_nxt  = instret_q + CNT_W'(1);
          end else begin
            mem_en_o     = 1'b1;
            pc_fetch_nxt = pc_fetch_q + ADDR_W'(1);
            pc_ex_nxt    = pc_fetch_q;
            ex_valid_nxt = 1'b1;
            instret_nxt  = instret_q + CNT_W'(ex_valid_q);
          end
        end
        HALTED: begin
          if (resume_i) begin
            mem_en_o     = 1'b1;
            pc_fetch_nxt = pc_fetch_q + ADDR_W'(1);
            pc_ex_nxt    = pc_fetch_q;
            ex_valid_nxt = 1'b1;
            halted_nxt   = 1'b0;
            state_nxt    = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q    <= RUN;
      pc_fetch_q <= PC_INIT;
      pc_ex_q    <= PC_INIT;
      ex_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      pc_fetch_q <= pc_fetch_nxt;
      pc_ex_q    <= pc_ex_nxt;
      ex_valid_q <= ex_valid_nxt;
      halted_q   <= halted_nxt;
      instret_q  <= instret_nxt;
    end
  end

  assign pc_fetch_o = pc_fetch_q;
  assign pc_ex_o    = pc_ex_q;
  assign ex_valid_o = ex_valid_q;
  assign halted_o   = halted_q;
  assign instret_o  = instret_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [11:0] redirect_pc_i;
  logic        halt_i;
  logic        resume_i;
  logic [11:0] pc_fetch_o;
  logic        mem_en_o;
  logic [11:0] pc_ex_o;
  logic        ex_valid_o;
  logic        halted_o;
  logic [31:0] instret_o;

  fetch_sequencer #(.ADDR_W(12), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .resume_i     (resume_i),
    .pc_fetch_o   (pc_fetch_o),
    .mem_en_o     (mem_en_o),
    .pc_ex_o      (pc_ex_o),
    .ex_valid_o   (ex_valid_o),
    .halted_o     (halted_o),
    .instret_o    (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the architectural state
  logic [11:0] m_pc, m_pc_ex;
  bit          m_valid, m_halted;
  logic [31:0] m_instret;
  bit          m_mem_en;
  logic        obs_mem_en;

  // One clock: drive inputs at the falling edge, sample mem_en_o before the
  // rising edge, advance the model at the rising edge, settle 1 time unit.
  task automatic step(input bit r, input bit s, input bit rd, input logic [11:0] tgt,
                      input bit h, input bit rs);
    logic [11:0] n_pc, n_pc_ex;
    bit          n_valid, n_halted;
    logic [31:0] n_instret;
    @(negedge clk);
    rst_n = r; stall_i = s; redirect_i = rd; redirect_pc_i = tgt; halt_i = h; resume_i = rs;
    n_pc = m_pc; n_pc_ex = m_pc_ex; n_valid = m_valid; n_halted = m_halted; n_instret = m_instret;
    m_mem_en = 1'b0;
    if (!r) begin
      n_pc = 12'h000; n_pc_ex = 12'h000; n_valid = 1'b0; n_halted = 1'b0; n_instret = 32'd0;
    end else if (m_halted) begin
      if (rs) begin
        m_mem_en = 1'b1; n_pc_ex = m_pc; n_pc = m_pc + 12'd1; n_valid = 1'b1; n_halted = 1'b0;
      end
    end else if (s) begin
      m_mem_en = 1'b0;
    end else if (m_valid && h) begin
      n_instret = m_instret + 32'd1; n_valid = 1'b0; n_halted = 1'b1;
      if (rd) n_pc = tgt;
    end else if (m_valid && rd) begin
      m_mem_en = 1'b1; n_pc_ex = m_pc; n_pc = tgt; n_valid = 1'b0; n_instret = m_instret + 32'd1;
    end else begin
      m_mem_en = 1'b1; n_pc_ex = m_pc; n_pc = m_pc + 12'd1; n_valid = 1'b1;
      n_instret = m_instret + (m_valid ? 32'd1 : 32'd0);
    end
    #1;
    obs_mem_en = mem_en_o;
    @(posedge clk);
    m_pc = n_pc; m_pc_ex = n_pc_ex; m_valid = n_valid; m_halted = n_halted; m_instret = n_instret;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 12'h000, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 12'h000, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (obs_mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%0b want=0", obs_mem_en); end
    total++; if (pc_fetch_o !== 12'h000) begin bad++; $display("FAIL reset_pc_fetch got=%h want=000", pc_fetch_o); end
    total++; if (pc_ex_o !== 12'h000) begin bad++; $display("FAIL reset_pc_ex got=%h want=000", pc_ex_o); end
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid_o); end
    total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted_o); end
    total++; if (instret_o !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret_o); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0, 12'h000, 0, 0);
      total++; if (obs_mem_en !== 1'b1) begin bad++; $display("FAIL seq_mem_en k=%0d got=%0b want=1", k, obs_mem_en); end
      total++; if (pc_fetch_o !== 12'(k)) begin bad++; $display("FAIL seq_pc k=%0d got=%h want=%h", k, pc_fetch_o, 12'(k)); end
      total++; if (pc_ex_o !== 12'(k - 1)) begin bad++; $display("FAIL seq_pc_ex k=%0d got=%h want=%h", k, pc_ex_o, 12'(k - 1)); end
      total++; if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL seq_valid k=%0d got=%0b want=1", k, ex_valid_o); end
    end
    total++; if (instret_o !== 32'd5) begin bad++; $display("FAIL seq_instret got=%0d want=5", instret_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    idle(4);
    total++; if (pc_fetch_o !== 12'h004 || pc_ex_o !== 12'h003) begin bad++; $display("FAIL redir_setup got=%h/%h want=004/003", pc_fetch_o, pc_ex_o); end
    step(1, 0, 1, 12'h040, 0, 0);
    total++; if (pc_fetch_o !== 12'h040) begin bad++; $display("FAIL redir_pc got=%h want=040", pc_fetch_o); end
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%0b want=0", ex_valid_o); end
    total++; if (instret_o !== 32'd4) begin bad++; $display("FAIL redir_instret got=%0d want=4", instret_o); end
    // A redirect presented on the bubble must be ignored
    step(1, 0, 1, 12'h200, 0, 0);
    total++; if (pc_ex_o !== 12'h040 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL redir_follow got=%h/%0b want=040/1", pc_ex_o, ex_valid_o); end
    total++; if (pc_fetch_o !== 12'h041) begin bad++; $display("FAIL redir_bubble_ignored got=%h want=041", pc_fetch_o); end
  endtask

  task automatic test_stall();
    logic [11:0] pf, pe;
    logic [31:0] ir;
    do_reset();
    idle(3);
    pf = pc_fetch_o; pe = pc_ex_o; ir = instret_o;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 12'h100, 0, 0);
      total++; if (obs_mem_en !== 1'b0) begin bad++; $display("FAIL stall_mem_en i=%0d got=%0b want=0", i, obs_mem_en); end
      total++; if (pc_fetch_o !== pf || pc_ex_o !== pe || ex_valid_o !== 1'b1 || instret_o !== ir) begin
        bad++; $display("FAIL stall_frozen i=%0d got=%h/%h/%0b/%0d want=%h/%h/1/%0d", i, pc_fetch_o, pc_ex_o, ex_valid_o, instret_o, pf, pe, ir);
      end
    end
    step(1, 0, 1, 12'h100, 0, 0);
    total++; if (pc_fetch_o !== 12'h100 || ex_valid_o !== 1'b0) begin bad++; $display("FAIL stall_redirect got=%h/%0b want=100/0", pc_fetch_o, ex_valid_o); end
    total++; if (pc_ex_o !== pf) begin bad++; $display("FAIL stall_redirect_ex got=%h want=%h", pc_ex_o, pf); end
  endtask

  task automatic test_halt();
    do_reset();
    idle(17);
    total++; if (pc_ex_o !== 12'h010) begin bad++; $display("FAIL halt_setup got=%h want=010", pc_ex_o); end
    step(1, 0, 0, 12'h000, 1, 0);
    total++; if (obs_mem_en !== 1'b0) begin bad++; $display("FAIL halt_mem_en got=%0b want=0", obs_mem_en); end
    total++; if (instret_o !== 32'd17) begin bad++; $display("FAIL halt_instret got=%0d want=17", instret_o); end
    for (int i = 0; i < 20; i++) begin
      step(1, 1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom), 0);
      total++; if (halted_o !== 1'b1 || ex_valid_o !== 1'b0 || pc_fetch_o !== 12'h011 || obs_mem_en !== 1'b0) begin
        bad++; $display("FAIL halt_hold i=%0d got=%0b/%0b/%h/%0b want=1/0/011/0", i, halted_o, ex_valid_o, pc_fetch_o, obs_mem_en);
      end
    end
    total++; if (instret_o !== 32'd17) begin bad++; $display("FAIL halt_hold_instret got=%0d want=17", instret_o); end
    step(1, 0, 0, 12'h000, 0, 1);
    total++; if (obs_mem_en !== 1'b1) begin bad++; $display("FAIL resume_mem_en got=%0b want=1", obs_mem_en); end
    total++; if (pc_ex_o !== 12'h011 || ex_valid_o !== 1'b1 || halted_o !== 1'b0) begin
      bad++; $display("FAIL resume got=%h/%0b/%0b want=011/1/0", pc_ex_o, ex_valid_o, halted_o);
    end
    total++; if (pc_fetch_o !== 12'h012) begin bad++; $display("FAIL resume_pc got=%h want=012", pc_fetch_o); end
    step(1, 0, 0, 12'h000, 0, 1);
    total++; if (instret_o !== 32'd18) begin bad++; $display("FAIL resume_instret got=%0d want=18", instret_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    idle(2);
    step(1, 0, 1, 12'hFFE, 0, 0);
    step(1, 0, 0, 12'h000, 0, 0);
    total++; if (pc_fetch_o !== 12'hFFF) begin bad++; $display("FAIL wrap_setup got=%h want=fff", pc_fetch_o); end
    step(1, 0, 0, 12'h000, 0, 0);
    total++; if (pc_fetch_o !== 12'h000 || pc_ex_o !== 12'hFFF) begin bad++; $display("FAIL wrap got=%h/%h want=000/fff", pc_fetch_o, pc_ex_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(3);
    step(1, 0, 0, 12'h000, 1, 0);
    step(0, 0, 0, 12'h000, 0, 1);
    total++; if (obs_mem_en !== 1'b0) begin bad++; $display("FAIL rst_halt_mem_en got=%0b want=0", obs_mem_en); end
    total++; if (halted_o !== 1'b0 || pc_fetch_o !== 12'h000 || pc_ex_o !== 12'h000 || ex_valid_o !== 1'b0 || instret_o !== 32'd0) begin
      bad++; $display("FAIL rst_halt got=%0b/%h/%h/%0b/%0d want=0/000/000/0/0", halted_o, pc_fetch_o, pc_ex_o, ex_valid_o, instret_o);
    end
    idle(3);
    step(1, 0, 1, 12'h300, 0, 0);
    step(0, 0, 1, 12'h300, 0, 0);
    total++; if (pc_fetch_o !== 12'h000 || pc_ex_o !== 12'h000 || ex_valid_o !== 1'b0 || instret_o !== 32'd0) begin
      bad++; $display("FAIL rst_bubble got=%h/%h/%0b/%0d want=000/000/0/0", pc_fetch_o, pc_ex_o, ex_valid_o, instret_o);
    end
    step(1, 0, 0, 12'h000, 0, 0);
    total++; if (pc_fetch_o !== 12'h001 || pc_ex_o !== 12'h000 || ex_valid_o !== 1'b1) begin
      bad++; $display("FAIL rst_restart got=%h/%h/%0b want=001/000/1", pc_fetch_o, pc_ex_o, ex_valid_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           12'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
      total++;
      if (obs_mem_en !== m_mem_en || pc_fetch_o !== m_pc || pc_ex_o !== m_pc_ex ||
          ex_valid_o !== m_valid || halted_o !== m_halted || instret_o !== m_instret) begin
        bad++;
        $display("FAIL rand i=%0d got en=%0b pc=%h ex=%h v=%0b h=%0b n=%0d want en=%0b pc=%h ex=%h v=%0b h=%0b n=%0d",
                 i, obs_mem_en, pc_fetch_o, pc_ex_o, ex_valid_o, halted_o, instret_o,
                 m_mem_en, m_pc, m_pc_ex, m_valid, m_halted, m_instret);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0; resume_i = 1'b0;
    m_pc = '0; m_pc_ex = '0; m_valid = 1'b0; m_halted = 1'b0; m_instret = '0; m_mem_en = 1'b0;
    obs_mem_en = 1'b0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
